// File: rtl/cpu_out_buffer.sv
// CPU result capture FIFO that drains each stored word as a byte stream, MSB first,
// over a valid/ready handshake. Words arriving while the FIFO is full are dropped and flagged.
module cpu_out_buffer #(
  parameter int WIDTH    = 24,
  parameter int DEPTH    = 16,
  parameter int PTRWIDTH = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                outFlag,
  input  logic [WIDTH-1:0]    out,
  input  logic                startIO,
  input  logic                byteReady,
  output logic                byteValid,
  output logic [7:0]          byteData,
  output logic [PTRWIDTH:0]   count,
  output logic                full,
  output logic                empty,
  output logic                overflow
);

  localparam int NBYTES = WIDTH / 8;
  localparam int IDXW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [PTRWIDTH:0]   DEPTH_C  = (PTRWIDTH+1)'(DEPTH);
  localparam logic [PTRWIDTH:0]   CNT_ONE  = (PTRWIDTH+1)'(1);
  localparam logic [PTRWIDTH:0]   CNT_ZERO = (PTRWIDTH+1)'(0);
  localparam logic [PTRWIDTH-1:0] PTR_ONE  = PTRWIDTH'(1);
  localparam logic [IDXW-1:0]     IDX_ONE  = IDXW'(1);
  localparam logic [IDXW-1:0]     IDX_ZERO = IDXW'(0);
  localparam logic [IDXW-1:0]     IDX_LAST = IDXW'(NBYTES - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t               state_r, state_nx_s;
  logic [WIDTH-1:0]     mem_r [DEPTH];
  logic [PTRWIDTH-1:0]  wr_ptr_r, rd_ptr_r;
  logic [PTRWIDTH:0]    count_r, count_nx_s;
  logic [WIDTH-1:0]     hold_r, hold_nx_s;
  logic [IDXW-1:0]      idx_r, idx_nx_s;
  logic                 byte_valid_r, byte_valid_nx_s;
  logic [7:0]           byte_data_r, byte_data_nx_s;
  logic                 full_r, empty_r, overflow_r;
  logic                 pop_s, wr_s, drop_s, accept_s, last_s;

  // Byte i of a word counted from the most significant end
  function automatic logic [7:0] sel_byte(input logic [WIDTH-1:0] w, input logic [IDXW-1:0] i);
    logic [WIDTH-1:0] sh;
    sh = w << {i, 3'b000};
    return sh[WIDTH-1 -: 8];
  endfunction

  assign pop_s    = (state_r == IDLE) && startIO && (count_r != CNT_ZERO);
  assign wr_s     = outFlag && ((count_r < DEPTH_C) || pop_s);
  assign drop_s   = outFlag && !wr_s;
  assign accept_s = (state_r == SEND) && byte_valid_r && byteReady;
  assign last_s   = (idx_r == IDX_LAST);

  // Occupancy next value from simultaneous write/pop
  always_comb begin
    count_nx_s = count_r;
    case ({wr_s, pop_s})
      2'b10:   count_nx_s = count_r + CNT_ONE;
      2'b01:   count_nx_s = count_r - CNT_ONE;
      default: count_nx_s = count_r;
    endcase
  end

  // Next-state logic for the drain FSM
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE:    state_nx_s = pop_s ? SEND : IDLE;
      SEND:    state_nx_s = (accept_s && last_s) ? IDLE : SEND;
      default: state_nx_s = IDLE;
    endcase
  end

  // Next values of the held word, byte index and the registered byte outputs
  always_comb begin
    hold_nx_s       = hold_r;
    idx_nx_s        = idx_r;
    byte_valid_nx_s = byte_valid_r;
    byte_data_nx_s  = byte_data_r;
    case (state_r)
      IDLE: begin
        if (pop_s) begin
          hold_nx_s       = mem_r[rd_ptr_r];
          idx_nx_s        = IDX_ZERO;
          byte_valid_nx_s = 1'b1;
          byte_data_nx_s  = sel_byte(mem_r[rd_ptr_r], IDX_ZERO);
        end else begin
          byte_valid_nx_s = 1'b0;
        end
      end
      SEND: begin
        if (accept_s) begin
          if (last_s) begin
            byte_valid_nx_s = 1'b0;
          end else begin
            idx_nx_s       = idx_r + IDX_ONE;
            byte_data_nx_s = sel_byte(hold_r, idx_r + IDX_ONE);
          end
        end else begin
          byte_valid_nx_s = 1'b1;
        end
      end
      default: byte_valid_nx_s = 1'b0;
    endcase
  end

  // State, pointers, occupancy flags and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= IDLE;
      wr_ptr_r     <= '0;
      rd_ptr_r     <= '0;
      count_r      <= '0;
      hold_r       <= '0;
      idx_r        <= '0;
      byte_valid_r <= 1'b0;
      byte_data_r  <= 8'h00;
      full_r       <= 1'b0;
      empty_r      <= 1'b1;
      overflow_r   <= 1'b0;
    end else begin
      state_r      <= state_nx_s;
      wr_ptr_r     <= wr_s  ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
      rd_ptr_r     <= pop_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
      count_r      <= count_nx_s;
      hold_r       <= hold_nx_s;
      idx_r        <= idx_nx_s;
      byte_valid_r <= byte_valid_nx_s;
      byte_data_r  <= byte_data_nx_s;
      full_r       <= (count_nx_s == DEPTH_C);
      empty_r      <= (count_nx_s == CNT_ZERO);
      overflow_r   <= overflow_r | drop_s;
    end
  end

  // Storage array; contents after reset are don't-care
  always_ff @(posedge clock) begin
    if (wr_s) begin
      mem_r[wr_ptr_r] <= out;
    end
  end

  assign byteValid = byte_valid_r;
  assign byteData  = byte_data_r;
  assign count     = count_r;
  assign full      = full_r;
  assign empty     = empty_r;
  assign overflow  = overflow_r;

endmodule

// File: tb/tb_cpu_out_buffer.sv
// Scenario bench for cpu_out_buffer: expected bytes are queued at strobe time and
// checked by a stream monitor as the DUT hands them over.
module tb_cpu_out_buffer;
  localparam int WIDTH = 24, DEPTH = 16, PTRWIDTH = 4;

  logic clock, reset, outFlag, startIO, byteReady;
  logic [WIDTH-1:0] out;
  logic byteValid, full, empty, overflow;
  logic [7:0] byteData;
  logic [PTRWIDTH:0] count;

  int total = 0, bad = 0;
  logic [7:0] sbq[$];
  logic [7:0] mon_exp;

  cpu_out_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PTRWIDTH(PTRWIDTH)) dut (
    .clock(clock), .reset(reset), .outFlag(outFlag), .out(out), .startIO(startIO),
    .byteReady(byteReady), .byteValid(byteValid), .byteData(byteData), .count(count),
    .full(full), .empty(empty), .overflow(overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Stream monitor: every handshake must match the next queued byte
  always @(negedge clock) begin
    if (reset === 1'b0 && byteValid === 1'b1 && byteReady === 1'b1) begin
      total++;
      if (sbq.size() == 0) begin
        bad++;
        $display("FAIL stream: got unexpected byte %h, none expected", byteData);
      end else begin
        mon_exp = sbq.pop_front();
        if (byteData !== mon_exp) begin
          bad++;
          $display("FAIL stream: got %h want %h", byteData, mon_exp);
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic strobe(input logic [23:0] w, input bit keep);
    outFlag = 1'b1;
    out = w;
    if (keep) begin
      sbq.push_back(w[23:16]);
      sbq.push_back(w[15:8]);
      sbq.push_back(w[7:0]);
    end
    step();
    outFlag = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && sbq.size() != 0; i++) step();
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d bytes outstanding want 0", sbq.size());
    end
    repeat (3) step();
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (byteValid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL wait_valid: got byteValid=%b want 1 within budget", byteValid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; outFlag = 1'b0; out = 24'h000000; startIO = 1'b0; byteReady = 1'b0;
    step(); step();
    total += 6;
    if (byteValid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", byteValid); end
    if (byteData !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", byteData); end
    if (count !== 5'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
    if (full !== 1'b0) begin bad++; $display("FAIL reset_full: got %b want 0", full); end
    if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty: got %b want 1", empty); end
    if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_single();
    startIO = 1'b1; byteReady = 1'b1;
    strobe(24'hA1B2C3, 1'b1);
    total += 2;
    if (count !== 5'd1) begin bad++; $display("FAIL single_count: got %0d want 1", count); end
    if (byteValid !== 1'b0) begin bad++; $display("FAIL single_early: got %b want 0", byteValid); end
    step();
    total += 2;
    if (byteValid !== 1'b1) begin bad++; $display("FAIL single_latency: got %b want 1", byteValid); end
    if (byteData !== 8'hA1) begin bad++; $display("FAIL single_first: got %h want a1", byteData); end
    drain();
    total++;
    if (empty !== 1'b1) begin bad++; $display("FAIL single_empty: got %b want 1", empty); end
  endtask

  task automatic test_overflow();
    startIO = 1'b0; byteReady = 1'b1;
    for (int i = 0; i < 16; i++) strobe(24'(i), 1'b1);
    strobe(24'hFFFFFF, 1'b0);
    total += 3;
    if (full !== 1'b1) begin bad++; $display("FAIL ovf_full: got %b want 1", full); end
    if (count !== 5'd16) begin bad++; $display("FAIL ovf_count: got %0d want 16", count); end
    if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    startIO = 1'b1;
    drain();
    total += 3;
    if (empty !== 1'b1) begin bad++; $display("FAIL ovf_empty: got %b want 1", empty); end
    if (count !== 5'd0) begin bad++; $display("FAIL ovf_drained: got %0d want 0", count); end
    if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
  endtask

  task automatic test_full_pop();
    startIO = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 16; i++) strobe(24'h100000 + 24'(i), 1'b1);
    total++;
    if (full !== 1'b1) begin bad++; $display("FAIL fullpop_full: got %b want 1", full); end
    startIO = 1'b1;
    strobe(24'hABCDEF, 1'b1);
    total += 2;
    if (count !== 5'd16) begin bad++; $display("FAIL fullpop_count: got %0d want 16", count); end
    if (overflow !== 1'b0) begin bad++; $display("FAIL fullpop_ovf: got %b want 0", overflow); end
    drain();
    total++;
    if (overflow !== 1'b0) begin bad++; $display("FAIL fullpop_ovf_end: got %b want 0", overflow); end
  endtask

  task automatic test_stall();
    logic [7:0] exp_d [5];
    bit pat [5];
    bit ok;
    exp_d = '{8'h12, 8'h34, 8'h34, 8'h34, 8'h56};
    pat   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    startIO = 1'b1; byteReady = 1'b0;
    strobe(24'h123456, 1'b1);
    wait_valid(ok);
    if (ok) begin
      for (int i = 0; i < 5; i++) begin
        total++;
        if (byteValid !== 1'b1 || byteData !== exp_d[i]) begin
          bad++;
          $display("FAIL stall_%0d: got v=%b d=%h want v=1 d=%h", i, byteValid, byteData, exp_d[i]);
        end
        byteReady = pat[i];
        step();
      end
      total++;
      if (byteValid !== 1'b0) begin bad++; $display("FAIL stall_end: got %b want 0", byteValid); end
    end
    byteReady = 1'b1;
    drain();
  endtask

  task automatic test_start_drop();
    bit ok;
    startIO = 1'b0; byteReady = 1'b1;
    strobe(24'h0F0E0D, 1'b1);
    strobe(24'h111111, 1'b0);
    strobe(24'h222222, 1'b0);
    total++;
    if (count !== 5'd3) begin bad++; $display("FAIL drop_count3: got %0d want 3", count); end
    startIO = 1'b1;
    wait_valid(ok);
    startIO = 1'b0;
    repeat (10) step();
    total += 3;
    if (byteValid !== 1'b0) begin bad++; $display("FAIL drop_idle: got %b want 0", byteValid); end
    if (count !== 5'd2) begin bad++; $display("FAIL drop_count2: got %0d want 2", count); end
    if (sbq.size() != 0) begin bad++; $display("FAIL drop_complete: got %0d bytes left want 0", sbq.size()); end
    sbq.push_back(8'h11); sbq.push_back(8'h11); sbq.push_back(8'h11);
    sbq.push_back(8'h22); sbq.push_back(8'h22); sbq.push_back(8'h22);
    startIO = 1'b1;
    drain();
  endtask

  task automatic test_reset_mid();
    bit ok;
    startIO = 1'b1; byteReady = 1'b1;
    strobe(24'h445566, 1'b1);
    strobe(24'h778899, 1'b1);
    wait_valid(ok);
    step();
    total++;
    if (byteData !== 8'h55) begin bad++; $display("FAIL rstmid_second: got %h want 55", byteData); end
    reset = 1'b1;
    sbq.delete();
    step();
    total += 4;
    if (byteValid !== 1'b0) begin bad++; $display("FAIL rstmid_valid: got %b want 0", byteValid); end
    if (count !== 5'd0) begin bad++; $display("FAIL rstmid_count: got %0d want 0", count); end
    if (overflow !== 1'b0) begin bad++; $display("FAIL rstmid_ovf: got %b want 0", overflow); end
    if (empty !== 1'b1) begin bad++; $display("FAIL rstmid_empty: got %b want 1", empty); end
    reset = 1'b0;
    step();
    strobe(24'hC0FFEE, 1'b1);
    drain();
    total++;
    if (empty !== 1'b1) begin bad++; $display("FAIL rstmid_after: got %b want 1", empty); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_full_pop();
    test_stall();
    test_start_drop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
